// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_sequencer_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned INSN_W = 32;
  localparam int unsigned DEFAULT_DISP_W = 22;

  localparam logic [ADDR_W-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0800;
  localparam logic [INSN_W-1:0] DEFAULT_HALT_WORD    = 32'h0000_0000;

  // Instruction field offsets (op[31:30], a[29], cond[28:25], disp22[21:0])
  localparam int unsigned OP_MSB     = 31;
  localparam int unsigned OP_LSB     = 30;
  localparam int unsigned A_BIT      = 29;
  localparam int unsigned COND_MSB   = 28;
  localparam int unsigned COND_LSB   = 25;
  localparam int unsigned DISP22_MSB = 21;
  localparam int unsigned DISP22_LSB = 0;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_HALT = 2'd3
  } fetch_state_e;

  // Next-PC source: sequential, branch target, or skip past an annulled slot
  typedef enum logic [1:0] {
    PC_SEL_SEQ    = 2'd0,
    PC_SEL_TARGET = 2'd1,
    PC_SEL_SKIP   = 2'd2
  } pc_sel_e;

endpackage

// File: rtl/fetch_sequencer_pc_next_unit.sv
// Combinational next PC/nPC selection for delayed-branch fetch.
module fetch_sequencer_pc_next_unit
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned DISP_W = DEFAULT_DISP_W
) (
  input  logic [ADDR_W-1:0] npc_i,
  input  logic [ADDR_W-1:0] br_pc_i,
  input  logic [DISP_W-1:0] br_disp_i,
  input  pc_sel_e           sel_i,
  output logic [ADDR_W-1:0] pc_d_o,
  output logic [ADDR_W-1:0] npc_d_o
);

  logic [ADDR_W-1:0] disp_sext;
  logic [ADDR_W-1:0] target;

  assign disp_sext = {{(ADDR_W-DISP_W){br_disp_i[DISP_W-1]}}, br_disp_i};
  assign target    = br_pc_i + disp_sext;

  // Pick the address pair to load once the current fetch is latched
  always_comb begin
    pc_d_o  = npc_i;
    npc_d_o = npc_i + ADDR_W'(1);
    case (sel_i)
      PC_SEL_TARGET: begin
        pc_d_o  = target;
        npc_d_o = target + ADDR_W'(1);
      end
      PC_SEL_SKIP: begin
        pc_d_o  = br_pc_i + ADDR_W'(2);
        npc_d_o = br_pc_i + ADDR_W'(3);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: PC/nPC, instruction register, delayed
// branches with annul, stall hold and halt on the end-of-program word.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter int unsigned       DISP_W       = DEFAULT_DISP_W,
  parameter logic [INSN_W-1:0] HALT_WORD    = DEFAULT_HALT_WORD
) (
  input  logic              CLOCK_50,
  input  logic              RESET_InHigh,
  output logic [ADDR_W-1:0] fetch_addr,
  input  logic [INSN_W-1:0] fetch_data,
  input  logic              stall,
  input  logic              br_req,
  input  logic              br_taken,
  input  logic              br_annul,
  input  logic [DISP_W-1:0] br_disp,
  output logic [INSN_W-1:0] ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  output logic              halted
);

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] npc_q;
  logic [INSN_W-1:0] ir_q;
  logic [ADDR_W-1:0] ir_pc_q;
  logic              ir_valid_q;
  logic              halted_q;

  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] npc_d;

  logic    fetch_en_c;
  logic    br_act_c;
  logic    annul_c;
  logic    halt_c;
  pc_sel_e pc_sel_c;

  // Decide whether this cycle fetches, resolves a branch, or halts
  always_comb begin
    fetch_en_c = ((state_q == ST_RUN) || (state_q == ST_HOLD)) && !stall;
    br_act_c   = fetch_en_c && br_req && ir_valid_q;
    annul_c    = br_act_c && !br_taken && br_annul;
    halt_c     = fetch_en_c && (fetch_data == HALT_WORD) && !annul_c;
    pc_sel_c   = PC_SEL_SEQ;
    if (br_act_c && br_taken) begin
      pc_sel_c = PC_SEL_TARGET;
    end else if (annul_c) begin
      pc_sel_c = PC_SEL_SKIP;
    end
  end

  fetch_sequencer_pc_next_unit #(
    .DISP_W (DISP_W)
  ) u_pc_next_unit (
    .npc_i     (npc_q),
    .br_pc_i   (ir_pc_q),
    .br_disp_i (br_disp),
    .sel_i     (pc_sel_c),
    .pc_d_o    (pc_d),
    .npc_d_o   (npc_d)
  );

  // Sequencer state, PC/nPC and instruction register
  always_ff @(posedge CLOCK_50) begin
    if (RESET_InHigh) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_VECTOR;
      npc_q      <= RESET_VECTOR + ADDR_W'(1);
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_BOOT: begin
          state_q <= ST_RUN;
        end
        ST_RUN, ST_HOLD: begin
          if (stall) begin
            state_q <= ST_HOLD;
          end else if (halt_c) begin
            ir_q       <= HALT_WORD;
            ir_pc_q    <= pc_q;
            ir_valid_q <= 1'b0;
            halted_q   <= 1'b1;
            state_q    <= ST_HALT;
          end else begin
            ir_q       <= fetch_data;
            ir_pc_q    <= pc_q;
            ir_valid_q <= !annul_c;
            pc_q       <= pc_d;
            npc_q      <= npc_d;
            state_q    <= ST_RUN;
          end
        end
        ST_HALT: begin
          state_q <= ST_HALT;
        end
        default: begin
          state_q <= ST_BOOT;
        end
      endcase
    end
  end

  assign fetch_addr = pc_q;
  assign ir         = ir_q;
  assign ir_pc      = ir_pc_q;
  assign ir_valid   = ir_valid_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed scenarios then random traffic.
module tb_fetch_sequencer;

  localparam logic [31:0] RV = 32'h0000_0800;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        br_req = 1'b0;
  logic        br_taken = 1'b0;
  logic        br_annul = 1'b0;
  logic [21:0] br_disp = '0;
  logic [31:0] fetch_addr;
  logic [31:0] fetch_data;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic        ir_valid;
  logic        halted;
  logic [31:0] halt_addr = 32'h0000_080E;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model of the architectural state after each edge
  logic [31:0] m_pc, m_npc, m_ir, m_irpc;
  logic        m_valid, m_halted, m_boot;

  typedef struct {
    logic [31:0] fa;
    logic [31:0] ir;
    logic [31:0] irpc;
    logic        v;
    logic        h;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  // Stub program memory: each word holds its own address, except the halt slot
  assign fetch_data = (fetch_addr == halt_addr) ? 32'h0 : fetch_addr;

  fetch_sequencer dut (
    .CLOCK_50     (clk),
    .RESET_InHigh (rst),
    .fetch_addr   (fetch_addr),
    .fetch_data   (fetch_data),
    .stall        (stall),
    .br_req       (br_req),
    .br_taken     (br_taken),
    .br_annul     (br_annul),
    .br_disp      (br_disp),
    .ir           (ir),
    .ir_pc        (ir_pc),
    .ir_valid     (ir_valid),
    .halted       (halted)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == halt_addr) ? 32'h0 : a;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, want);
    end
  endtask

  task automatic bound_fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s t=%0t got=timeout want=reached", name, $time);
  endtask

  // Drive one cycle of inputs, advance the model, queue the expected result
  task automatic cyc(input logic r, input logic s, input logic bq, input logic bt,
                     input logic ba, input logic [21:0] d);
    logic [31:0] w, b, t;
    logic        is_br, ann;
    rst = r; stall = s; br_req = bq; br_taken = bt; br_annul = ba; br_disp = d;
    if (r) begin
      m_pc = RV; m_npc = RV + 32'd1; m_ir = '0; m_irpc = '0;
      m_valid = 1'b0; m_halted = 1'b0; m_boot = 1'b1;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (!m_halted && !s) begin
      w     = mem_word(m_pc);
      is_br = bq && m_valid;
      ann   = is_br && !bt && ba;
      if (w == 32'h0 && !ann) begin
        m_ir = 32'h0; m_irpc = m_pc; m_valid = 1'b0; m_halted = 1'b1;
      end else begin
        b = m_irpc;
        m_ir = w; m_irpc = m_pc; m_valid = !ann;
        if (is_br && bt) begin
          t = b + {{10{d[21]}}, d};
          m_pc = t; m_npc = t + 32'd1;
        end else if (ann) begin
          m_pc = b + 32'd2; m_npc = b + 32'd3;
        end else begin
          m_pc = m_npc; m_npc = m_npc + 32'd1;
        end
      end
    end
    exp_q.push_back('{m_pc, m_ir, m_irpc, m_valid, m_halted});
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 22'h0);
  endtask

  // Run sequentially until the model's IR holds the given address
  task automatic run_to(input logic [31:0] a, input string name);
    int n = 0;
    while (!(m_valid && m_irpc == a) && n < 64) begin
      idle();
      n++;
    end
    if (n >= 64) bound_fail(name);
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation
  initial begin
    exp_t e;
    @(posedge clk);
    forever begin
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("fetch_addr", fetch_addr, e.fa);
        chk("ir", ir, e.ir);
        chk("ir_pc", ir_pc, e.irpc);
        chk("ir_valid", 32'(ir_valid), 32'(e.v));
        chk("halted", 32'(halted), 32'(e.h));
      end
      @(posedge clk);
    end
  end

  initial begin
    int n;
    int k;
    logic [21:0] d;
    logic r;

    // Reset, boot, sequential fetch
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 22'h0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 22'h0);
    idle();
    run_to(32'h807, "reach_807");
    // Taken branch at 0x807, displacement -4: delay slot 0x808 then 0x803
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 22'h3FFFFC);
    run_to(32'h804, "reach_804");
    // Three stall cycles with PC at 0x805
    repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 22'h0);
    run_to(32'h80D, "reach_80D");
    // Not-taken annulled branch: halt word in the slot must not halt
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 22'h000005);
    repeat (3) idle();

    // Sequential run into the halt word at 0x80E
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 22'h0);
    n = 0;
    while (!m_halted && n < 64) begin
      idle();
      n++;
    end
    if (n >= 64) bound_fail("reach_halt");
    repeat (4) idle();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 22'h0);
    repeat (4) idle();

    // Reset in the same cycle as a taken branch and a stall
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 22'h000010);
    repeat (2) idle();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 199) == 0) || (m_halted && $urandom_range(0, 7) == 0);
      if (r) halt_addr = RV + 32'($urandom_range(0, 60));
      k = int'($urandom_range(0, 32)) - 16;
      d = k[21:0];
      cyc(r, ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), d);
    end

    repeat (3) @(posedge clk);
    #3;
    if (exp_q.size() != 0) bound_fail("scoreboard_drain");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
